// File: rtl/wb_gain_ctrl_pkg.sv
// Shared definitions for the white-balance gain scheduler: gain format
// defaults, divider geometry and FSM state encoding.
package wb_gain_ctrl_pkg;

  localparam int GAIN_FRAC_DEF = 8;
  localparam int GAIN_W_DEF    = 10;

  localparam int DIV_DVD_W  = 16;
  localparam int DIV_DSR_W  = 8;
  localparam int DIV_CYCLES = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DIV_R  = 3'd1,
    ST_DIV_B  = 3'd2,
    ST_SMOOTH = 3'd3,
    ST_PEND   = 3'd4
  } wb_state_e;

endpackage

// File: rtl/wb_div_serial.sv
// Restoring 16/8 unsigned serial divider, one quotient bit per cycle,
// fixed 16-cycle latency from start to a single-cycle done pulse.
module wb_div_serial
  import wb_gain_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [DIV_DVD_W-1:0] dividend,
  input  logic [DIV_DSR_W-1:0] divisor,
  output logic [DIV_DVD_W-1:0] quotient,
  output logic                 done
);

  localparam int CNT_W = $clog2(DIV_CYCLES + 1);

  logic [DIV_DVD_W-1:0] dvd_q, dvd_d;
  logic [DIV_DSR_W-1:0] dsr_q, dsr_d;
  logic [DIV_DSR_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 done_q, done_d;
  logic [DIV_DSR_W:0]   trial;

  // Dividend shifts out at the top while quotient bits shift in at the bottom,
  // so dvd_q holds the quotient once the down-counter expires. A zero divisor
  // would yield all ones, i.e. the saturated quotient.
  always_comb begin
    dvd_d  = dvd_q;
    dsr_d  = dsr_q;
    rem_d  = rem_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    trial  = {rem_q, dvd_q[DIV_DVD_W-1]};
    if (start) begin
      dvd_d = dividend;
      dsr_d = divisor;
      rem_d = '0;
      cnt_d = CNT_W'(DIV_CYCLES);
    end else if (cnt_q != '0) begin
      if (trial >= {1'b0, dsr_q}) begin
        rem_d = DIV_DSR_W'(trial - {1'b0, dsr_q});
        dvd_d = {dvd_q[DIV_DVD_W-2:0], 1'b1};
      end else begin
        rem_d = trial[DIV_DSR_W-1:0];
        dvd_d = {dvd_q[DIV_DVD_W-2:0], 1'b0};
      end
      cnt_d  = cnt_q - CNT_W'(1);
      done_d = (cnt_q == CNT_W'(1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_q  <= '0;
      dsr_q  <= '0;
      rem_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      dvd_q  <= dvd_d;
      dsr_q  <= dsr_d;
      rem_q  <= rem_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign quotient = dvd_q;
  assign done     = done_q;

endmodule

// File: rtl/wb_gain_ctrl.sv
// Per-frame grey-world white-balance gain scheduler with IIR smoothing and
// frame-boundary commit. Define WB_MANUAL_EN to add manual R/B gain override.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for stat_valid; latches the frame averages
// ST_DIV_R  | shared divider computes G/R (zero divisor -> GAIN_MAX)
// ST_DIV_B  | shared divider computes G/B (zero divisor -> GAIN_MAX)
// ST_SMOOTH | one-cycle IIR step of working gains toward the targets
// ST_PEND   | waiting for a vsync rising edge to commit the outputs
module wb_gain_ctrl
  import wb_gain_ctrl_pkg::*;
#(
  parameter int                GAIN_FRAC    = GAIN_FRAC_DEF,
  parameter int                GAIN_W       = GAIN_W_DEF,
  parameter logic [GAIN_W-1:0] GAIN_MIN     = GAIN_W'(128),
  parameter logic [GAIN_W-1:0] GAIN_MAX     = GAIN_W'(1023),
  parameter int                SMOOTH_SHIFT = 2
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_en,
  input  logic              per_frame_vsync,
  input  logic              stat_valid,
  input  logic [7:0]        stat_avg_r,
  input  logic [7:0]        stat_avg_g,
  input  logic [7:0]        stat_avg_b,
`ifdef WB_MANUAL_EN
  input  logic              manual_sel,
  input  logic [GAIN_W-1:0] manual_gain_r,
  input  logic [GAIN_W-1:0] manual_gain_b,
`endif
  output logic [GAIN_W-1:0] out_gain_r,
  output logic [GAIN_W-1:0] out_gain_g,
  output logic [GAIN_W-1:0] out_gain_b,
  output logic              gain_updated,
  output logic              busy,
  output logic              stat_overrun
);

  localparam logic [GAIN_W-1:0] GAIN_ONE = GAIN_W'(1 << GAIN_FRAC);
  localparam int QW = DIV_DVD_W;
  localparam int SW = GAIN_W + 2;

  wb_state_e         state_q, state_d;
  logic [7:0]        lat_r_q, lat_r_d, lat_g_q, lat_g_d, lat_b_q, lat_b_d;
  logic [GAIN_W-1:0] tgt_r_q, tgt_r_d, tgt_b_q, tgt_b_d;
  logic [GAIN_W-1:0] work_r_q, work_r_d, work_b_q, work_b_d;
  logic [GAIN_W-1:0] out_r_q, out_r_d, out_b_q, out_b_d;
  logic              upd_q, upd_d;
  logic              ovr_q, ovr_d;
  logic              vs_q, vs_d, vs_edge_q, vs_edge_d;

  logic              div_start;
  logic [QW-1:0]     div_dividend;
  logic [7:0]        div_divisor;
  logic [QW-1:0]     div_quotient;
  logic              div_done;
  logic [GAIN_W-1:0] commit_r, commit_b;

  function automatic logic [GAIN_W-1:0] clamp_q(input logic [QW-1:0] q);
    if (q < QW'(GAIN_MIN)) return GAIN_MIN;
    if (q > QW'(GAIN_MAX)) return GAIN_MAX;
    return q[GAIN_W-1:0];
  endfunction

  function automatic logic [GAIN_W-1:0] smooth_step(input logic [GAIN_W-1:0] cur,
                                                    input logic [GAIN_W-1:0] tgt);
    logic signed [SW-1:0] diff;
    logic signed [SW-1:0] step;
    logic signed [SW-1:0] sum;
    diff = $signed({2'b00, tgt}) - $signed({2'b00, cur});
    step = diff >>> SMOOTH_SHIFT;
    sum  = $signed({2'b00, cur}) + step;
    if (sum < $signed({2'b00, GAIN_MIN})) return GAIN_MIN;
    if (sum > $signed({2'b00, GAIN_MAX})) return GAIN_MAX;
    return sum[GAIN_W-1:0];
  endfunction

  wb_div_serial u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (div_dividend),
    .divisor  (div_divisor),
    .quotient (div_quotient),
    .done     (div_done)
  );

  always_comb begin
    state_d      = state_q;
    lat_r_d      = lat_r_q;
    lat_g_d      = lat_g_q;
    lat_b_d      = lat_b_q;
    tgt_r_d      = tgt_r_q;
    tgt_b_d      = tgt_b_q;
    work_r_d     = work_r_q;
    work_b_d     = work_b_q;
    out_r_d      = out_r_q;
    out_b_d      = out_b_q;
    upd_d        = 1'b0;
    ovr_d        = ovr_q | (stat_valid && (state_q != ST_IDLE));
    vs_d         = per_frame_vsync;
    vs_edge_d    = per_frame_vsync & ~vs_q;
    div_start    = 1'b0;
    div_dividend = {lat_g_q, 8'b0};
    div_divisor  = lat_b_q;

    commit_r = wb_en ? work_r_q : GAIN_ONE;
    commit_b = wb_en ? work_b_q : GAIN_ONE;
`ifdef WB_MANUAL_EN
    if (manual_sel) begin
      commit_r = manual_gain_r;
      commit_b = manual_gain_b;
    end
`endif

    // Each divide is launched on the transition edge into its state, feeding
    // the divider straight from the source so no cycle is spent on setup.
    case (state_q)
      ST_IDLE: begin
        if (stat_valid) begin
          lat_r_d      = stat_avg_r;
          lat_g_d      = stat_avg_g;
          lat_b_d      = stat_avg_b;
          div_dividend = {stat_avg_g, 8'b0};
          div_divisor  = stat_avg_r;
          div_start    = (stat_avg_r != 8'd0);
          state_d      = ST_DIV_R;
        end
      end
      ST_DIV_R: begin
        if (lat_r_q == 8'd0 || div_done) begin
          tgt_r_d   = (lat_r_q == 8'd0) ? GAIN_MAX : clamp_q(div_quotient);
          div_start = (lat_b_q != 8'd0);
          state_d   = ST_DIV_B;
        end
      end
      ST_DIV_B: begin
        if (lat_b_q == 8'd0 || div_done) begin
          tgt_b_d = (lat_b_q == 8'd0) ? GAIN_MAX : clamp_q(div_quotient);
          state_d = ST_SMOOTH;
        end
      end
      ST_SMOOTH: begin
        work_r_d = smooth_step(work_r_q, tgt_r_q);
        work_b_d = smooth_step(work_b_q, tgt_b_q);
        state_d  = ST_PEND;
      end
      ST_PEND: begin
        if (vs_edge_q) begin
          out_r_d = commit_r;
          out_b_d = commit_b;
          upd_d   = (commit_r != out_r_q) || (commit_b != out_b_q);
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      lat_r_q   <= '0;
      lat_g_q   <= '0;
      lat_b_q   <= '0;
      tgt_r_q   <= '0;
      tgt_b_q   <= '0;
      work_r_q  <= GAIN_ONE;
      work_b_q  <= GAIN_ONE;
      out_r_q   <= GAIN_ONE;
      out_b_q   <= GAIN_ONE;
      upd_q     <= 1'b0;
      ovr_q     <= 1'b0;
      vs_q      <= 1'b0;
      vs_edge_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      lat_r_q   <= lat_r_d;
      lat_g_q   <= lat_g_d;
      lat_b_q   <= lat_b_d;
      tgt_r_q   <= tgt_r_d;
      tgt_b_q   <= tgt_b_d;
      work_r_q  <= work_r_d;
      work_b_q  <= work_b_d;
      out_r_q   <= out_r_d;
      out_b_q   <= out_b_d;
      upd_q     <= upd_d;
      ovr_q     <= ovr_d;
      vs_q      <= vs_d;
      vs_edge_q <= vs_edge_d;
    end
  end

  assign out_gain_r   = out_r_q;
  assign out_gain_g   = GAIN_ONE;
  assign out_gain_b   = out_b_q;
  assign gain_updated = upd_q;
  assign busy         = (state_q != ST_IDLE);
  assign stat_overrun = ovr_q;

endmodule

// File: tb/tb_wb_gain_ctrl.sv
// Bench for wb_gain_ctrl: two instances (SMOOTH_SHIFT 0 and 2) share stimulus;
// a behavioural model pushes expected commits that are popped on gain_updated.
`timescale 1ns/1ps
module tb_wb_gain_ctrl;

  localparam int GW = 10;

  typedef struct packed {
    logic [GW-1:0] r;
    logic [GW-1:0] g;
    logic [GW-1:0] b;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, wb_en, vsync, stat_valid;
  logic [7:0]    avg_r, avg_g, avg_b;
  logic [GW-1:0] r0, g0, b0, r2, g2, b2;
  logic          upd0, upd2, busy0, busy2, ovr0, ovr2;
`ifdef WB_MANUAL_EN
  logic          manual_sel;
  logic [GW-1:0] man_r, man_b;
`endif

  int   n_run  = 0;
  int   n_fail = 0;
  int   cnt0   = 0;
  int   cnt2   = 0;
  exp_t sb0[$];
  exp_t sb2[$];

  int m_work[2][2];
  int m_out[2][2];
  bit m_pend;

  wb_gain_ctrl #(.SMOOTH_SHIFT(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .wb_en(wb_en), .per_frame_vsync(vsync),
    .stat_valid(stat_valid), .stat_avg_r(avg_r), .stat_avg_g(avg_g), .stat_avg_b(avg_b),
`ifdef WB_MANUAL_EN
    .manual_sel(manual_sel), .manual_gain_r(man_r), .manual_gain_b(man_b),
`endif
    .out_gain_r(r0), .out_gain_g(g0), .out_gain_b(b0),
    .gain_updated(upd0), .busy(busy0), .stat_overrun(ovr0)
  );

  wb_gain_ctrl #(.SMOOTH_SHIFT(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .wb_en(wb_en), .per_frame_vsync(vsync),
    .stat_valid(stat_valid), .stat_avg_r(avg_r), .stat_avg_g(avg_g), .stat_avg_b(avg_b),
`ifdef WB_MANUAL_EN
    .manual_sel(manual_sel), .manual_gain_r(man_r), .manual_gain_b(man_b),
`endif
    .out_gain_r(r2), .out_gain_g(g2), .out_gain_b(b2),
    .gain_updated(upd2), .busy(busy2), .stat_overrun(ovr2)
  );

  // ---------------- model ----------------
  function automatic int m_clamp(input int v);
    if (v < 128) return 128;
    if (v > 1023) return 1023;
    return v;
  endfunction

  function automatic int m_target(input int g, input int x);
    if (x == 0) return 1023;
    return m_clamp((g * 256) / x);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_work[i][0] = 256; m_work[i][1] = 256;
      m_out[i][0]  = 256; m_out[i][1]  = 256;
    end
    m_pend = 1'b0;
    sb0.delete();
    sb2.delete();
  endtask

  task automatic model_stats(input int r, input int g, input int b);
    int tr, tb, sh;
    tr = m_target(g, r);
    tb = m_target(g, b);
    for (int i = 0; i < 2; i++) begin
      sh = (i == 0) ? 0 : 2;
      m_work[i][0] = m_clamp(m_work[i][0] + ((tr - m_work[i][0]) >>> sh));
      m_work[i][1] = m_clamp(m_work[i][1] + ((tb - m_work[i][1]) >>> sh));
    end
    m_pend = 1'b1;
  endtask

  task automatic model_commit();
    int   nr, nb;
    exp_t e;
    if (!m_pend) return;
    for (int i = 0; i < 2; i++) begin
      nr = wb_en ? m_work[i][0] : 256;
      nb = wb_en ? m_work[i][1] : 256;
`ifdef WB_MANUAL_EN
      if (manual_sel) begin nr = int'(man_r); nb = int'(man_b); end
`endif
      if (nr != m_out[i][0] || nb != m_out[i][1]) begin
        e.r = GW'(nr); e.g = GW'(256); e.b = GW'(nb);
        if (i == 0) sb0.push_back(e); else sb2.push_back(e);
      end
      m_out[i][0] = nr;
      m_out[i][1] = nb;
    end
    m_pend = 1'b0;
  endtask

  // ---------------- scoreboard monitors ----------------
  always @(negedge clk) begin : mon0
    exp_t e;
    if (upd0 === 1'b1) begin
      cnt0++;
      n_run++;
      if (sb0.size() == 0) begin
        n_fail++;
        $display("FAIL sb0_unexpected: gain_updated with r=%0d b=%0d, required no pulse", r0, b0);
      end else begin
        e = sb0.pop_front();
        if ({r0, g0, b0} !== e) begin
          n_fail++;
          $display("FAIL sb0_commit: got r=%0d g=%0d b=%0d, required r=%0d g=%0d b=%0d",
                   r0, g0, b0, e.r, e.g, e.b);
        end
      end
    end
  end

  always @(negedge clk) begin : mon2
    exp_t e;
    if (upd2 === 1'b1) begin
      cnt2++;
      n_run++;
      if (sb2.size() == 0) begin
        n_fail++;
        $display("FAIL sb2_unexpected: gain_updated with r=%0d b=%0d, required no pulse", r2, b2);
      end else begin
        e = sb2.pop_front();
        if ({r2, g2, b2} !== e) begin
          n_fail++;
          $display("FAIL sb2_commit: got r=%0d g=%0d b=%0d, required r=%0d g=%0d b=%0d",
                   r2, g2, b2, e.r, e.g, e.b);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic apply_reset();
    rst_n = 1'b0; stat_valid = 1'b0; vsync = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  task automatic send_stats(input int r, input int g, input int b);
    @(posedge clk); #1;
    avg_r = 8'(r); avg_g = 8'(g); avg_b = 8'(b);
    stat_valid = 1'b1;
    @(posedge clk); #1;
    stat_valid = 1'b0;
    model_stats(r, g, b);
  endtask

  task automatic wait_pend();
    repeat (40) @(posedge clk);
    #1;
  endtask

  task automatic pulse_vsync();
    model_commit();
    vsync = 1'b1;
    repeat (3) @(posedge clk);
    #1 vsync = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int cyc;
    cyc = 0;
    while ((busy0 !== 1'b0 || busy2 !== 1'b0) && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_run++;
    if (cyc >= 100) begin
      n_fail++;
      $display("FAIL %s_idle: busy still high after %0d cycles, required 0", tag, cyc);
    end
  endtask

  task automatic check_drained(input string tag);
    n_run++;
    if (sb0.size() != 0 || sb2.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: pending expected commits %0d/%0d, required 0/0",
               tag, sb0.size(), sb2.size());
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    n_run++;
    if ({r0, g0, b0, upd0, busy0, ovr0} !== {10'd256, 10'd256, 10'd256, 3'b000}) begin
      n_fail++;
      $display("FAIL reset0: got r=%0d g=%0d b=%0d upd=%b busy=%b ovr=%b, required 256/256/256/0/0/0",
               r0, g0, b0, upd0, busy0, ovr0);
    end
    n_run++;
    if ({r2, g2, b2, upd2, busy2, ovr2} !== {10'd256, 10'd256, 10'd256, 3'b000}) begin
      n_fail++;
      $display("FAIL reset2: got r=%0d g=%0d b=%0d upd=%b busy=%b ovr=%b, required 256/256/256/0/0/0",
               r2, g2, b2, upd2, busy2, ovr2);
    end
  endtask

  task automatic test_basic();
    int c0, c2;
    c0 = cnt0; c2 = cnt2;
    wb_en = 1'b1;
    send_stats(64, 128, 32);
    @(negedge clk);
    n_run++;
    if (busy0 !== 1'b1) begin
      n_fail++; $display("FAIL basic_busy: got %b, required 1", busy0);
    end
    wait_pend();
    pulse_vsync();
    wait_idle("basic");
    n_run++;
    if ({r0, g0, b0} !== {10'd512, 10'd256, 10'd1023}) begin
      n_fail++; $display("FAIL basic_shift0: got %0d/%0d/%0d, required 512/256/1023", r0, g0, b0);
    end
    n_run++;
    if ({r2, b2} !== {10'd320, 10'd447}) begin
      n_fail++; $display("FAIL basic_shift2: got r=%0d b=%0d, required 320/447", r2, b2);
    end
    n_run++;
    if (cnt0 - c0 != 1 || cnt2 - c2 != 1) begin
      n_fail++; $display("FAIL basic_pulses: got %0d/%0d, required 1/1", cnt0 - c0, cnt2 - c2);
    end
    check_drained("basic");
  endtask

  task automatic test_overrun();
    int c0, c2;
    c0 = cnt0; c2 = cnt2;
    send_stats(64, 128, 32);
    repeat (4) @(posedge clk);
    #1 avg_r = 8'd200; avg_g = 8'd10; avg_b = 8'd200; stat_valid = 1'b1;
    @(posedge clk);
    #1 stat_valid = 1'b0;
    @(negedge clk);
    n_run++;
    if ({ovr0, ovr2, busy0, busy2} !== 4'b1111) begin
      n_fail++; $display("FAIL overrun_flags: got ovr=%b%b busy=%b%b, required 11/11", ovr0, ovr2, busy0, busy2);
    end
    wait_pend();
    pulse_vsync();
    wait_idle("overrun");
    n_run++;
    if ({r2, b2, r0, b0} !== {10'd368, 10'd591, 10'd512, 10'd1023}) begin
      n_fail++; $display("FAIL overrun_gains: got r2=%0d b2=%0d r0=%0d b0=%0d, required 368/591/512/1023",
                         r2, b2, r0, b0);
    end
    n_run++;
    if (cnt0 - c0 != 0 || cnt2 - c2 != 1 || ovr0 !== 1'b1) begin
      n_fail++; $display("FAIL overrun_pulses: got %0d/%0d ovr0=%b, required 0/1 ovr0=1", cnt0 - c0, cnt2 - c2, ovr0);
    end
    check_drained("overrun");
  endtask

  task automatic test_early_vsync();
    int c0, c2;
    c0 = cnt0; c2 = cnt2;
    send_stats(100, 100, 50);
    repeat (19) @(posedge clk);
    #1 vsync = 1'b1;
    repeat (3) @(posedge clk);
    #1 vsync = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    n_run++;
    if (cnt0 != c0 || cnt2 != c2 || {r0, r2} !== {10'd512, 10'd368}) begin
      n_fail++; $display("FAIL early_vsync: got pulses %0d/%0d r0=%0d r2=%0d, required 0/0 512/368",
                         cnt0 - c0, cnt2 - c2, r0, r2);
    end
    repeat (20) @(posedge clk);
    #1;
    pulse_vsync();
    wait_idle("early");
    n_run++;
    if ({r0, b0, r2, b2} !== {10'd256, 10'd512, 10'd340, 10'd571}) begin
      n_fail++; $display("FAIL early_commit: got %0d/%0d %0d/%0d, required 256/512 340/571", r0, b0, r2, b2);
    end
    check_drained("early");
  endtask

  task automatic test_zero_div();
    send_stats(0, 128, 128);
    wait_pend();
    pulse_vsync();
    wait_idle("zero_r");
    n_run++;
    if ({r0, b0} !== {10'd1023, 10'd256}) begin
      n_fail++; $display("FAIL zero_r: got r=%0d b=%0d, required 1023/256", r0, b0);
    end
    send_stats(10, 0, 20);
    wait_pend();
    pulse_vsync();
    wait_idle("zero_g");
    n_run++;
    if ({r0, b0} !== {10'd128, 10'd128}) begin
      n_fail++; $display("FAIL zero_g: got r=%0d b=%0d, required 128/128", r0, b0);
    end
    check_drained("zero");
  endtask

  task automatic test_wb_disable();
    int c0, c2;
    apply_reset();
    c0 = cnt0; c2 = cnt2;
    wb_en = 1'b0;
    send_stats(64, 128, 32);
    wait_pend();
    pulse_vsync();
    wait_idle("wb_off");
    n_run++;
    if ({r0, b0, r2, b2} !== {4{10'd256}} || cnt0 != c0 || cnt2 != c2) begin
      n_fail++; $display("FAIL wb_off: got %0d/%0d %0d/%0d pulses %0d/%0d, required all 256, 0/0",
                         r0, b0, r2, b2, cnt0 - c0, cnt2 - c2);
    end
    wb_en = 1'b1;
    send_stats(64, 128, 32);
    wait_pend();
    pulse_vsync();
    wait_idle("wb_on");
    n_run++;
    if ({r0, r2, b2} !== {10'd512, 10'd368, 10'd591}) begin
      n_fail++; $display("FAIL wb_track: got r0=%0d r2=%0d b2=%0d, required 512/368/591", r0, r2, b2);
    end
    check_drained("wb");
  endtask

  task automatic test_reset_mid();
    send_stats(64, 128, 32);
    repeat (20) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_run++;
    if ({r0, b0, r2, b2} !== {4{10'd256}} || {busy0, busy2, upd0, upd2} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_mid: got %0d/%0d %0d/%0d busy=%b%b, required all 256 busy 00",
                         r0, b0, r2, b2, busy0, busy2);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    send_stats(64, 128, 32);
    wait_pend();
    pulse_vsync();
    wait_idle("after_rst");
    n_run++;
    if ({r0, b0, r2, b2} !== {10'd512, 10'd1023, 10'd320, 10'd447}) begin
      n_fail++; $display("FAIL after_rst: got %0d/%0d %0d/%0d, required 512/1023 320/447", r0, b0, r2, b2);
    end
    check_drained("after_rst");
  endtask

`ifdef WB_MANUAL_EN
  task automatic test_manual();
    manual_sel = 1'b1; man_r = 10'd300; man_b = 10'd700;
    send_stats(64, 128, 32);
    wait_pend();
    pulse_vsync();
    wait_idle("manual");
    n_run++;
    if ({r0, g0, b0, r2} !== {10'd300, 10'd256, 10'd700, 10'd300}) begin
      n_fail++; $display("FAIL manual: got r0=%0d g0=%0d b0=%0d r2=%0d, required 300/256/700/300", r0, g0, b0, r2);
    end
    manual_sel = 1'b0;
    send_stats(64, 128, 32);
    wait_pend();
    pulse_vsync();
    wait_idle("manual_off");
    n_run++;
    if (r2 !== 10'd404) begin
      n_fail++; $display("FAIL manual_track: got r2=%0d, required 404", r2);
    end
    check_drained("manual");
  endtask
`endif

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; wb_en = 1'b1; vsync = 1'b0; stat_valid = 1'b0;
    avg_r = '0; avg_g = '0; avg_b = '0;
`ifdef WB_MANUAL_EN
    manual_sel = 1'b0; man_r = '0; man_b = '0;
`endif
    model_reset();
    test_reset();
    test_basic();
    test_overrun();
    test_early_vsync();
    test_zero_div();
    test_wb_disable();
    test_reset_mid();
`ifdef WB_MANUAL_EN
    test_manual();
`endif
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
